// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared HC-SR04 state encoding, default timing and time-to-cycle conversions.
package hcsr04_pkg;
  localparam int unsigned DEF_CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned DEF_TRIG_US = 10;
  localparam int unsigned DEF_CYCLE_MS = 60;
  localparam int unsigned DEF_ECHO_TIMEOUT_US = 38_000;
  localparam int unsigned ECHO_US_PER_CM = 58;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF} hcsr04State_t;
  function automatic int unsigned usToCyc(input longint unsigned clkHz, input longint unsigned us);
    return 32'(clkHz / 64'd1_000_000 * us);
  endfunction
  function automatic int unsigned msToCyc(input longint unsigned clkHz, input longint unsigned ms);
    return 32'(clkHz / 64'd1_000 * ms);
  endfunction
endpackage

// File: rtl/ultrasonic_trigger_gen_if.sv
// ultrasonic_trigger_gen_if: sensor pins plus measurement status between trigger generator and its user.
interface ultrasonic_trigger_gen_if;
  logic enable;
  logic echo;
  logic trig;
  logic busy;
  logic echo_active;
  logic cycle_done;
  logic timeout;
  modport master (
    input enable, echo,
    output trig, busy, echo_active, cycle_done, timeout
  );
  modport slave (
    output enable, echo,
    input trig, busy, echo_active, cycle_done, timeout
  );
endinterface

// File: rtl/echo_sync.sv
// echo_sync: two-flop synchronizer for the echo pin followed by rise/fall pulse detection.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echoPin,
  output logic rise,
  output logic fall
);
  logic s1, s2, prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1 <= echoPin;
      s2 <= s1;
      prev <= s2;
    end
  end
  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;
endmodule

// File: rtl/ultrasonic_trigger_gen.sv
// ultrasonic_trigger_gen: HC-SR04 trigger pulse generator and echo handshake tracker.
// Define ECHO_TIMEOUT_EN to abandon a measurement whose echo never completes.
module ultrasonic_trigger_gen
  import hcsr04_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned TRIG_US = DEF_TRIG_US,
  parameter int unsigned CYCLE_MS = DEF_CYCLE_MS,
  parameter int unsigned ECHO_TIMEOUT_US = DEF_ECHO_TIMEOUT_US
) (
  input logic clk,
  input logic rst,
  ultrasonic_trigger_gen_if.master bus
);
  localparam int unsigned TRIG_CYC = usToCyc(CLK_FREQ_HZ, TRIG_US);
  localparam int unsigned CYCLE_CYC = msToCyc(CLK_FREQ_HZ, CYCLE_MS);
  localparam int unsigned ECHO_TO_CYC = usToCyc(CLK_FREQ_HZ, ECHO_TIMEOUT_US);
  localparam int CW = $clog2(CYCLE_CYC) + 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLE_CYC - 1);
  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYC - 1);
  if (TRIG_CYC == 0 || CYCLE_CYC <= TRIG_CYC + ECHO_TO_CYC + 4) begin : gBadTiming
    $error("cycle period must exceed trigger width plus echo timeout plus 4 cycles");
  end
  hcsr04State_t state;
  logic [CW-1:0] cycCnt;
  logic echoRise, echoFall, toExpired;
  echo_sync uSync (
    .clk(clk),
    .rst(rst),
    .echoPin(bus.echo),
    .rise(echoRise),
    .fall(echoFall)
  );
  // cycCnt measures from the trigger rise, so HOLDOFF alone fixes the trigger period
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cycCnt <= '0;
      bus.trig <= 1'b0;
      bus.busy <= 1'b0;
      bus.echo_active <= 1'b0;
      bus.cycle_done <= 1'b0;
    end else begin
      bus.cycle_done <= 1'b0;
      if (state != IDLE && cycCnt != CYC_LAST) cycCnt <= cycCnt + 1'b1;
      case (state)
        IDLE: if (bus.enable) begin
          state <= TRIG;
          cycCnt <= '0;
          bus.trig <= 1'b1;
          bus.busy <= 1'b1;
        end
        TRIG: if (cycCnt == TRIG_LAST) begin
          state <= WAIT_RISE;
          bus.trig <= 1'b0;
        end
        WAIT_RISE: if (echoRise) begin
          state <= WAIT_FALL;
          bus.echo_active <= 1'b1;
        end else if (toExpired) state <= HOLDOFF;
        WAIT_FALL: if (echoFall || toExpired) begin
          state <= HOLDOFF;
          bus.echo_active <= 1'b0;
          bus.cycle_done <= echoFall;
        end
        HOLDOFF: if (cycCnt == CYC_LAST) begin
          state <= bus.enable ? TRIG : IDLE;
          cycCnt <= '0;
          bus.trig <= bus.enable;
          bus.busy <= bus.enable;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ECHO_TIMEOUT_EN
  localparam int TW = $clog2(ECHO_TO_CYC) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(ECHO_TO_CYC - 1);
  logic [TW-1:0] toCnt;
  logic waiting;
  assign waiting = state == WAIT_RISE || state == WAIT_FALL;
  assign toExpired = toCnt == TO_LAST;
  // an awaited edge arriving on the expiry cycle takes priority over the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      toCnt <= '0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= toExpired && (state == WAIT_RISE ? !echoRise : state == WAIT_FALL && !echoFall);
      if (state == TRIG) toCnt <= '0;
      else if (waiting && !toExpired) toCnt <= toCnt + 1'b1;
    end
  end
`else
  assign toExpired = 1'b0;
  assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_ultrasonic_trigger_gen.sv
// tb_ultrasonic_trigger_gen: scoreboard bench; stimulus queues timed output events, a monitor matches them.
module tb_ultrasonic_trigger_gen;
  typedef enum int {TRIG_RISE, BUSY_RISE, TRIG_FALL, ECHO_ACT, DONE, TMO, BUSY_FALL} kind_e;
  typedef struct {
    kind_e kind;
    int at;
  } ev_t;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  ev_t sb[$];
  logic trigQ = 1'b0, busyQ = 1'b0, eaQ = 1'b0;
  ultrasonic_trigger_gen_if bus ();
  ultrasonic_trigger_gen #(
    .CLK_FREQ_HZ(1_000_000),
    .TRIG_US(10),
    .CYCLE_MS(1),
    .ECHO_TIMEOUT_US(500)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic expect_ev(kind_e k, int at);
    sb.push_back('{k, at});
  endtask
  task automatic seen(kind_e k);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL event: got %s at cycle %0d, required no event", k.name(), cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind == k && e.at == cyc) passed++;
      else $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d", k.name(), cyc, e.kind.name(), e.at);
    end
  endtask
  task automatic chk(string name, logic got, logic want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %b, required %b at cycle %0d", name, got, want, cyc);
  endtask
  task automatic at(int c);
    while (cyc < c) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (bus.trig && !trigQ) seen(TRIG_RISE);
    if (bus.busy && !busyQ) seen(BUSY_RISE);
    if (!bus.trig && trigQ) seen(TRIG_FALL);
    if (bus.echo_active && !eaQ) seen(ECHO_ACT);
    if (bus.cycle_done) seen(DONE);
    if (bus.timeout) seen(TMO);
    if (!bus.busy && busyQ) seen(BUSY_FALL);
    trigQ = bus.trig;
    busyQ = bus.busy;
    eaQ = bus.echo_active;
  end
  initial begin
    int b;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.echo = 1'b0;
    at(3);
    chk("reset trig", bus.trig, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset echo_active", bus.echo_active, 1'b0);
    chk("reset cycle_done", bus.cycle_done, 1'b0);
    chk("reset timeout", bus.timeout, 1'b0);
    rst = 1'b0;
    // normal echo 20 cycles after trig fall, 100 wide; then a cycle with no echo
    b = 6;
    at(b);
    expect_ev(TRIG_RISE, b + 1);
    expect_ev(BUSY_RISE, b + 1);
    expect_ev(TRIG_FALL, b + 11);
    expect_ev(ECHO_ACT, b + 34);
    expect_ev(DONE, b + 134);
    expect_ev(TRIG_RISE, b + 1001);
    expect_ev(TRIG_FALL, b + 1011);
`ifdef ECHO_TIMEOUT_EN
    expect_ev(TMO, b + 1511);
    expect_ev(TRIG_RISE, b + 2001);
    expect_ev(TRIG_FALL, b + 2011);
`endif
    expect_ev(BUSY_FALL, b + 2021);
    bus.enable = 1'b1;
    at(b + 31);
    bus.echo = 1'b1;
    at(b + 131);
    bus.echo = 1'b0;
`ifndef ECHO_TIMEOUT_EN
    at(b + 2005);
    chk("busy held without echo", bus.busy, 1'b1);
`endif
    at(b + 2020);
    bus.enable = 1'b0;
    rst = 1'b1;
    at(b + 2022);
    rst = 1'b0;
    // echo already high at trigger; enable dropped during WAIT_FALL
    b = 2040;
    at(b);
    expect_ev(TRIG_RISE, b + 1);
    expect_ev(BUSY_RISE, b + 1);
    expect_ev(TRIG_FALL, b + 11);
    expect_ev(ECHO_ACT, b + 83);
    expect_ev(DONE, b + 123);
    expect_ev(BUSY_FALL, b + 1001);
    bus.echo = 1'b1;
    bus.enable = 1'b1;
    at(b + 60);
    bus.echo = 1'b0;
    at(b + 80);
    bus.echo = 1'b1;
    at(b + 100);
    bus.enable = 1'b0;
    at(b + 120);
    bus.echo = 1'b0;
    // reset in the middle of the trigger pulse
    b = 3100;
    at(b);
    expect_ev(TRIG_RISE, b + 1);
    expect_ev(BUSY_RISE, b + 1);
    expect_ev(TRIG_FALL, b + 6);
    expect_ev(BUSY_FALL, b + 6);
    expect_ev(TRIG_RISE, b + 9);
    expect_ev(BUSY_RISE, b + 9);
    expect_ev(TRIG_FALL, b + 19);
`ifdef ECHO_TIMEOUT_EN
    expect_ev(TMO, b + 519);
    expect_ev(BUSY_FALL, b + 1009);
`else
    expect_ev(BUSY_FALL, b + 1101);
`endif
    bus.enable = 1'b1;
    at(b + 5);
    rst = 1'b1;
    at(b + 8);
    rst = 1'b0;
    at(b + 20);
    bus.enable = 1'b0;
`ifndef ECHO_TIMEOUT_EN
    at(b + 1100);
    rst = 1'b1;
    at(b + 1102);
    rst = 1'b0;
`endif
    at(b + 1200);
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL pending events: got %0d never seen, first %s at cycle %0d, required 0", sb.size(), sb[0].kind.name(), sb[0].at);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ultrasonic_trigger_gen.md
Name: ultrasonic_trigger_gen

Overview:
- Initiator side of the HC-SR04 ultrasonic ranging interface; the echo-width distance measurement block is the receiver.
- Issues the 10 us trigger pulse and tracks the echo handshake: rise, fall, and optional timeout.
- Enforces the sensor's minimum cycle period between triggers.
- Sits beside the distance measurement logic and drives the sensor's TRIG pin directly.

Parameters:
- CLK_FREQ_HZ, 50000000: system clock frequency; all time parameters are converted to cycles from this.
- TRIG_US, 10: trigger pulse width in microseconds; TRIG_CYC = CLK_FREQ_HZ/1e6*TRIG_US.
- CYCLE_MS, 60: minimum period from one trigger rise to the next; CYCLE_CYC.
- ECHO_TIMEOUT_US, 38000: maximum time from trigger fall to echo fall; ECHO_TO_CYC.
- Elaboration constraint: CYCLE_CYC > TRIG_CYC + ECHO_TO_CYC + 4.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: run periodic measurements while high.
- echo, input, 1: asynchronous echo pin from the sensor.
- trig, output, 1: trigger pin to the sensor.
- busy, output, 1: high in any state other than IDLE.
- echo_active, output, 1: high while in WAIT_FALL.
- cycle_done, output, 1: one-cycle pulse when an echo completes normally.
- timeout, output, 1: one-cycle pulse when the echo timeout expires.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: trig=0, busy=0, echo_active=0, cycle_done=0, timeout=0; state=IDLE; all counters 0; synchronizer flops 0.
- Reset mid-operation: trig drops at the next clk edge; no cycle_done or timeout pulse is produced.
- Echo input: passes through a 2-flop synchronizer, then a registered edge detector. A pin edge is seen 3 cycles later as a one-cycle rise or fall pulse.
- Cycle counter: cleared on entry to TRIG; increments every cycle outside IDLE; saturates at CYCLE_CYC-1.
- State IDLE:
  - trig=0.
  - If enable=1, go to TRIG; trig is high on the next cycle (1-cycle latency).
- State TRIG:
  - trig=1 for exactly TRIG_CYC cycles, then go to WAIT_RISE.
  - The timeout counter is cleared on exit.
- State WAIT_RISE:
  - Waits for a synced rising edge only; an echo already high on entry is ignored until it falls and rises again.
  - On rise, go to WAIT_FALL.
- State WAIT_FALL:
  - echo_active=1.
  - On fall, pulse cycle_done and go to HOLDOFF.
- Timeout counter: increments in WAIT_RISE and WAIT_FALL.
  - When it reaches ECHO_TO_CYC-1 without the awaited edge, pulse timeout and go to HOLDOFF.
  - If the awaited edge and timeout expiry occur in the same cycle, the edge wins.
- State HOLDOFF:
  - Waits until the cycle counter equals CYCLE_CYC-1.
  - Then goes to TRIG if enable=1, else IDLE.
  - With enable held high, consecutive trig rises are exactly CYCLE_CYC cycles apart.
- enable deasserted mid-cycle: the current cycle completes through HOLDOFF, then the block goes to IDLE. No early abort.
- Echo edges outside WAIT_RISE and WAIT_FALL are ignored.
- Counter widths are $clog2 of the corresponding cycle constant plus 1; counters never wrap.

Optional Feature:
- Macro: ECHO_TIMEOUT_EN.
- Defined:
  - The timeout counter and timeout logic described above are present.
- Undefined:
  - No timeout counter.
  - timeout is tied to 0.
  - WAIT_RISE and WAIT_FALL wait indefinitely.
  - Recovery from a missing echo is by rst only.

Decomposition:
- Shared package hcsr04_pkg:
  - State enum {IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF}.
  - Cycle-conversion functions (us/ms to cycles).
  - Default timing constants; the receiver block also uses these for the echo distance scale.
- Sub-module echo_sync: 2-flop synchronizer plus rise/fall pulse detector, reusable by the receiver.

Test Plan (CLK_FREQ_HZ=1000000, TRIG_US=10, CYCLE_MS=1, ECHO_TIMEOUT_US=500):
- Reset, then enable=1: trig high 1 cycle later for exactly 10 cycles; busy=1 from the same cycle.
- Echo high 20 cycles after trig fall, width 100 cycles: echo_active asserts 3 cycles after the echo rise; cycle_done pulses once 3 cycles after the echo fall; next trig rise is exactly 1000 cycles after the first.
- No echo, ECHO_TIMEOUT_EN defined: timeout pulses 500 cycles after trig fall; next trig still at 1000 cycles. Same stimulus with the macro undefined: timeout stays 0 and busy stays 1 indefinitely.
- Echo held high before the trigger and through WAIT_RISE: no echo_active until echo goes low and rises again.
- enable dropped during WAIT_FALL: cycle_done still pulses; the block enters IDLE at cycle 1000; no further trig.
- rst asserted mid-TRIG: trig=0 and busy=0 the next cycle; no pulses; a new trig occurs 1 cycle after rst release with enable=1.
